// File: rtl/weight_stream_rom.sv
// Row-wide weight ROM/RAM that streams bursts of consecutive rows (with address
// wrap) through a 2-entry skid FIFO under valid/ready flow control.
module weight_stream_rom #(
  parameter int DEPTH     = 32,
  parameter int LANES     = 10,
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W:0]        row_count,
  output logic                   busy,
  output logic                   done,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [LANES*WIDTH-1:0] wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]      out_index,
  output logic                   out_last
);

  localparam int DW = LANES * WIDTH;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     rd_data_q;
  logic [ADDR_W-1:0] inflight_idx_q;
  logic              inflight_last_q;
  logic [DW-1:0]     fifo_data_q [2];
  logic [ADDR_W-1:0] fifo_idx_q  [2];
  logic              fifo_last_q [2];

  logic              head_valid, head_last, pop, bypass, push, fifo_pop, issue;
  logic [DW-1:0]     head_data;
  logic [ADDR_W-1:0] head_idx;
  logic [2:0]        occ;

  // The in-flight read register acts as the FIFO's front when the FIFO is
  // empty, which is what gives first-beat latency of two cycles.
  always_comb begin
    head_valid = (fifo_cnt_q != 2'd0) || inflight_q;
    head_data  = (fifo_cnt_q != 2'd0) ? fifo_data_q[rd_ptr_q] : rd_data_q;
    head_idx   = (fifo_cnt_q != 2'd0) ? fifo_idx_q[rd_ptr_q]  : inflight_idx_q;
    head_last  = (fifo_cnt_q != 2'd0) ? fifo_last_q[rd_ptr_q] : inflight_last_q;
    pop        = head_valid && out_ready;
    bypass     = pop && (fifo_cnt_q == 2'd0);
    push       = inflight_q && !bypass;
    fifo_pop   = pop && (fifo_cnt_q != 2'd0);
    occ        = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    issue      = (state_q == STREAM) && (issue_cnt_q < count_q) &&
                 ((occ < 3'd2) || (pop && (occ == 3'd2)));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;
    inflight_d  = issue;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ fifo_pop;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          count_d     = row_count;
          issue_cnt_d = '0;
          state_d     = (row_count == '0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          addr_d      = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + CNT_ONE;
        end
        if (pop && head_last) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Read-first memory: the read samples the old row before the write lands.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data_q       <= mem[addr_q];
      inflight_idx_q  <= addr_q;
      inflight_last_q <= (issue_cnt_q == count_q - CNT_ONE);
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data_q;
      fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign out_valid = head_valid;
  assign out_data  = head_valid ? head_data : '0;
  assign out_index = head_valid ? head_idx  : '0;
  assign out_last  = head_valid && head_last;

endmodule

// File: tb/tb_weight_stream_rom.sv
// Scoreboard bench for weight_stream_rom: stimulus queues expected beats, a
// negedge monitor pops and compares every transfer.
module tb_weight_stream_rom;

  localparam int DEPTH = 32;
  localparam int LANES = 10;
  localparam int WIDTH = 16;
  localparam int AW    = 5;
  localparam int DW    = LANES * WIDTH;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, wr_en, out_valid, out_ready, out_last;
  logic [AW-1:0] base_addr, wr_addr, out_index;
  logic [AW:0]   row_count;
  logic [DW-1:0] wr_data, out_data;

  logic [DW-1:0] model [DEPTH];
  beat_t         sb [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_cnt = 0;
  int            xfer_cnt = 0;
  int            last_xfer_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  weight_stream_rom #(.DEPTH(DEPTH), .LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_count(row_count), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake pops one expected beat; stalls must hold the beat.
  always @(negedge clk) begin
    if (prev_stall && !rst) begin
      check("stall_valid", DW'(out_valid), DW'(1));
      check("stall_data", out_data, prev_data);
      check("stall_index", DW'(out_index), DW'(prev_idx));
      check("stall_last", DW'(out_last), DW'(prev_last));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", DW'(out_index), '1);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", out_data, e.d);
        check("beat_index", DW'(out_index), DW'(e.idx));
        check("beat_last", DW'(out_last), DW'(e.last));
      end
      xfer_cnt++;
      if (out_last) last_xfer_cyc = cyc_cnt;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_index;
    prev_last  = out_last;
  end

  task automatic wr_row(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic run_burst(input int base, input int cnt, input bit toggle,
                           input bit chk_first, input bit f_write);
    bit seen_done;
    bit pat [4];
    beat_t e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    seen_done = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      e.idx  = AW'((base + i) % DEPTH);
      e.d    = model[(base + i) % DEPTH];
      e.last = (i == cnt - 1);
      sb.push_back(e);
    end
    xfer_cnt = 0;
    last_xfer_cyc = -1;
    out_ready = 1'b1;
    base_addr = AW'(base); row_count = (AW+1)'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (chk_first && c == 0) check("valid_before_latency", DW'(out_valid), DW'(0));
      if (chk_first && c == 1) begin
        check("first_valid_latency", DW'(out_valid), DW'(1));
        check("first_index", DW'(out_index), DW'(base % DEPTH));
      end
      if (done) begin
        seen_done = 1'b1;
        if (cnt == 0) check("done_after_empty_start", DW'(c), DW'(0));
        else check("done_after_last", DW'(cyc_cnt), DW'(last_xfer_cyc + 1));
        check("busy_in_finish", DW'(busy), DW'(1));
        break;
      end
      if (c > 0) check("busy_in_stream", DW'(busy), DW'(1));
      out_ready = toggle ? pat[c % 4] : 1'b1;
      if (f_write && c == 0) begin
        wr_en = 1'b1; wr_addr = AW'(base); wr_data = {LANES{16'hA5A5}};
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    if (f_write) model[base] = {LANES{16'hA5A5}};
    check("done_seen", DW'(seen_done), DW'(1));
    out_ready = 1'b1;
    tick();
    check("done_one_cycle", DW'(done), DW'(0));
    check("busy_idle", DW'(busy), DW'(0));
    check("xfer_count", DW'(xfer_cnt), DW'(cnt));
    check("scoreboard_empty", DW'(sb.size()), DW'(0));
    sb.delete();
  endtask

  initial begin
    bit done_flag;
    rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_valid", DW'(out_valid), DW'(0));
    check("rst_last", DW'(out_last), DW'(0));
    check("rst_index", DW'(out_index), DW'(0));
    check("rst_data", out_data, '0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < DEPTH; r++) wr_row(r, {LANES{16'(r)}});

    run_burst(0, 32, 1'b0, 1'b1, 1'b0);   // A
    run_burst(30, 4, 1'b0, 1'b1, 1'b0);   // B
    run_burst(3, 5, 1'b1, 1'b0, 1'b0);    // C
    run_burst(0, 0, 1'b0, 1'b0, 1'b0);    // D
    run_burst(7, 1, 1'b0, 1'b1, 1'b1);    // F: read-first
    run_burst(7, 1, 1'b0, 1'b1, 1'b0);    // F: new data visible
    run_burst(20, 40, 1'b0, 1'b1, 1'b0);  // wrap with count > DEPTH

    // E: reset on the third beat, with a colliding write that must be dropped
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      e.idx = AW'(10 + i); e.d = model[10 + i]; e.last = (i == 7);
      sb.push_back(e);
    end
    xfer_cnt = 0;
    out_ready = 1'b1; base_addr = AW'(10); row_count = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("e_third_beat_valid", DW'(out_valid), DW'(1));
    check("e_third_beat_index", DW'(out_index), DW'(12));
    rst = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = {LANES{16'hDEAD}};
    tick();
    rst = 1'b0; wr_en = 1'b0;
    sb.delete();
    check("e_valid_after_rst", DW'(out_valid), DW'(0));
    check("e_busy_after_rst", DW'(busy), DW'(0));
    check("e_xfers_before_rst", DW'(xfer_cnt), DW'(3));
    done_flag = 1'b0;
    repeat (6) begin
      if (done) done_flag = 1'b1;
      tick();
    end
    check("e_no_done", DW'(done_flag), DW'(0));
    run_burst(0, 2, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
